// File: rtl/uart_transmitter.sv
// UART transmit path: ready/valid word in, framed serial bits out on tx_o.
// Frame = start, WORD_LEN data bits, optional parity, 1 or 2 stop bits; idles high.
module uart_transmitter #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int WORD_LEN  = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_LEN-1:0] tx_data_in,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                tx_o,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W    = $clog2(WORD_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    baud_cnt, baud_next;
    logic [BIT_W-1:0]    bit_cnt, bit_next;
    logic [WORD_LEN-1:0] shift_reg, shift_next;
    logic                parity_bit, parity_next;
    logic                done_next;
    logic                tx_next;
    logic                baud_tick;

    assign baud_tick = (baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign tx_ready  = (state == S_IDLE);

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        baud_next   = baud_tick ? '0 : baud_cnt + 1'b1;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        parity_next = parity_bit;
        done_next   = 1'b0;

        case (state)
            S_IDLE: begin
                baud_next = '0;
                if (tx_valid) begin
                    shift_next  = tx_data_in;
                    parity_next = (^tx_data_in) ^ (PARITY == 1);
                    bit_next    = '0;
                    state_next  = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    bit_next   = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_next = (MSB_FIRST != 0) ? {shift_reg[WORD_LEN-2:0], 1'b0}
                                                  : {1'b0, shift_reg[WORD_LEN-1:1]};
                    if (bit_cnt == BIT_W'(WORD_LEN - 1)) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    bit_next   = '0;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        bit_next   = '0;
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The line level is decoded from the next state so tx_o stays in step
    // with the state register while still coming straight off a flop.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = (MSB_FIRST != 0) ? shift_next[WORD_LEN-1] : shift_next[0];
            S_PARITY: tx_next = parity_next;
            default:  tx_next = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_o       <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx_o       <= tx_next;
            tx_busy    <= (state_next != S_IDLE);
            tx_done    <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: four parameter variants share one clock;
// stimulus queues expected line sequences, a monitor decodes and compares them.
module tb_uart_transmitter;

    localparam int BIT_CLKS = 10;

    typedef struct {
        logic [11:0] seq;    // line bits, first transmitted bit is seq[nbits-1]
        int          nbits;
        int          gap;    // required clocks from previous tx_done to start, -1 = don't care
        bit          abort;  // frame is expected to be cut short by reset
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] valid = 4'b0000;
    logic [3:0] ready, line, busy, done;
    int         sel = 0;

    frame_t     exp_q[$];
    int         n_vec = 0;
    int         n_fail = 0;
    int         frames_seen = 0;
    bit         mon_active = 1'b0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) u_def (
        .clk(clk), .reset(rst), .tx_data_in(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_o(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(2)) u_even (
        .clk(clk), .reset(rst), .tx_data_in(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_o(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1)) u_odd (
        .clk(clk), .reset(rst), .tx_data_in(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_o(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    uart_transmitter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2),
                       .MSB_FIRST(0)) u_stop2 (
        .clk(clk), .reset(rst), .tx_data_in(tx_data), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx_o(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue the expected frame, then offer the word on the selected instance.
    task automatic send(input logic [7:0] d, input logic [11:0] seq, input int nbits,
                        input int gap, input bit abort);
        frame_t f;
        bit     got = 1'b0;
        f.seq = seq; f.nbits = nbits; f.gap = gap; f.abort = abort;
        exp_q.push_back(f);
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = ready[sel];
        end
        check("send_ready_timeout", {31'd0, got}, 32'd1);
        tx_data    = d;
        valid[sel] = 1'b1;
        @(negedge clk);
        valid[sel] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && !mon_active && !busy[sel];
        end
        check("idle_timeout", {31'd0, idle}, 32'd1);
    endtask

    // Monitor: decodes each frame on the selected line and scores it.
    int     cyc = 0;
    int     last_end = -1000;
    frame_t cur;
    bit     aborted;
    int     bad;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) continue;
            if (done[sel]) begin
                n_fail++;
                $display("FAIL spurious_tx_done: got 1 expected 0 at cycle %0d", cyc);
            end
            if (line[sel] == 1'b0) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: got frame %0d expected none", frames_seen);
                    for (int i = 0; i < 200 && line[sel] == 1'b0; i++) begin
                        @(negedge clk);
                        cyc++;
                    end
                    continue;
                end
                mon_active = 1'b1;
                cur = exp_q.pop_front();
                if (cur.gap >= 0)
                    check($sformatf("frame%0d_gap", frames_seen), cyc - last_end, cur.gap);
                aborted = 1'b0;
                for (int b = 0; b < cur.nbits && !aborted; b++) begin
                    bad = 0;
                    for (int t = 0; t < BIT_CLKS; t++) begin
                        if (b != 0 || t != 0) begin
                            @(negedge clk);
                            cyc++;
                        end
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (line[sel] !== cur.seq[cur.nbits-1-b] || busy[sel] !== 1'b1 ||
                            done[sel] !== 1'b0)
                            bad++;
                    end
                    if (!aborted)
                        check($sformatf("frame%0d_bit%0d_bad_cycles", frames_seen, b), bad, 0);
                end
                check($sformatf("frame%0d_aborted", frames_seen), {31'd0, aborted},
                      {31'd0, cur.abort});
                if (!aborted) begin
                    @(negedge clk);
                    cyc++;
                    check($sformatf("frame%0d_end_done", frames_seen), {31'd0, done[sel]}, 32'd1);
                    check($sformatf("frame%0d_end_line", frames_seen), {31'd0, line[sel]}, 32'd1);
                    check($sformatf("frame%0d_end_busy", frames_seen), {31'd0, busy[sel]}, 32'd0);
                    check($sformatf("frame%0d_end_ready", frames_seen), {31'd0, ready[sel]}, 32'd1);
                    last_end = cyc;
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_line%0d", k),  {31'd0, line[k]},  32'd1);
            check($sformatf("reset_busy%0d", k),  {31'd0, busy[k]},  32'd0);
            check($sformatf("reset_done%0d", k),  {31'd0, done[k]},  32'd0);
            check($sformatf("reset_ready%0d", k), {31'd0, ready[k]}, 32'd1);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Defaults, 0xA5: start, 1010_0101, stop
        sel = 0;
        send(8'hA5, 12'b0101001011, 10, -1, 1'b0);
        wait_idle();

        // Even parity, 0xA5: parity 0
        sel = 1;
        send(8'hA5, 12'b01010010101, 11, -1, 1'b0);
        wait_idle();

        // Odd parity, 0xA5 -> 1, 0x01 -> 0
        sel = 2;
        send(8'hA5, 12'b01010010111, 11, -1, 1'b0);
        wait_idle();
        send(8'h01, 12'b00000000101, 11, -1, 1'b0);
        wait_idle();

        // Two stop bits, LSB first, 0x3C: data 0,0,1,1,1,1,0,0
        sel = 3;
        send(8'h3C, 12'b00011110011, 11, -1, 1'b0);
        wait_idle();

        // Back-to-back with tx_valid held: 0x55 then 0xAA, second start 1 clk after tx_done
        sel = 0;
        begin
            frame_t f;
            f.seq = 12'b0010101011; f.nbits = 10; f.gap = -1; f.abort = 1'b0;
            exp_q.push_back(f);
            f.seq = 12'b0101010101; f.nbits = 10; f.gap = 1;  f.abort = 1'b0;
            exp_q.push_back(f);
        end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = ready[0];
        end
        check("b2b_first_ready", {31'd0, got}, 32'd1);
        tx_data  = 8'h55;
        valid[0] = 1'b1;
        @(negedge clk);
        tx_data = 8'hAA;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = ready[0];
        end
        check("b2b_second_ready", {31'd0, got}, 32'd1);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (40) @(negedge clk);
        tx_data  = 8'hFF;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        wait_idle();
        repeat (150) @(negedge clk);
        check("frames_after_b2b", frames_seen, 7);

        // Reset 35 clocks into a frame aborts it without tx_done
        send(8'hA5, 12'b0101001011, 10, -1, 1'b1);
        repeat (35) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_line",  {31'd0, line[0]},  32'd1);
        check("abort_busy",  {31'd0, busy[0]},  32'd0);
        check("abort_ready", {31'd0, ready[0]}, 32'd1);
        check("abort_done",  {31'd0, done[0]},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", {31'd0, done[0]}, 32'd0);

        // Recovery send 0x0F: 0000_1111
        send(8'h0F, 12'b0000011111, 10, -1, 1'b0);
        wait_idle();
        repeat (20) @(negedge clk);

        check("total_frames", frames_seen, 9);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Transmit side of the team's UART link; pairs with the existing UART receiver on the same clock domain.
- Accepts a parallel word through a ready/valid handshake and serialises it onto tx_o as: start bit, data bits, optional parity bit, 1 or 2 stop bits.
- Bit order defaults to MSB first, matching the receiver's left-shift capture.
- Sits between the host/register logic and the pad; the line idles high.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division) clocks per bit, minimum 2.
- WORD_LEN, 8, data bits per frame, 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- MSB_FIRST, 1, 1 = send bit WORD_LEN-1 first, 0 = send bit 0 first.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data_in  in  WORD_LEN  word to send; sampled only on acceptance.
- tx_valid  in  1  host requests transmission of tx_data_in.
- tx_ready  out  1  high only in IDLE; a transfer is accepted on a clk edge where tx_valid & tx_ready.
- tx_o  out  1  serial line, registered output.
- tx_busy  out  1  high from the cycle after acceptance until the frame ends.
- tx_done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (synchronous, wins over everything):
  - state = IDLE; tx_o = 1; tx_busy = 0; tx_done = 0; tx_ready = 1.
  - Baud counter, bit counter and shift register are cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_o = 1.
  - On acceptance: latch tx_data_in into the shift register, compute the parity bit from the latched word, clear the baud counter, go to START.
  - tx_o goes low on the edge after acceptance (latency 1 clk).
- Baud counter:
  - Counts 0..BAUD_DIV-1 and is cleared at every state change.
  - It does not run free; every bit lasts exactly BAUD_DIV clocks.
  - baud_tick = (count == BAUD_DIV-1).
- START:
  - tx_o = 0.
  - On baud_tick go to DATA with bit counter = 0.
- DATA:
  - tx_o = current data bit (MSB or LSB of the shift register per MSB_FIRST).
  - On baud_tick, shift and increment the bit counter.
  - When baud_tick and bit counter == WORD_LEN-1: go to PARITY if PARITY != 0, else go to STOP.
- PARITY:
  - tx_o = parity bit.
  - Even parity: the bit equals the XOR of the data bits.
  - Odd parity: the bit equals the inverse of that XOR.
  - On baud_tick go to STOP.
- STOP:
  - tx_o = 1 for STOP_BITS x BAUD_DIV clocks; the stop-bit count uses the bit counter.
  - On the final baud_tick: assert tx_done for that one cycle, deassert tx_busy, go to IDLE.
- Frame length: (1 + WORD_LEN + (PARITY != 0) + STOP_BITS) x BAUD_DIV clocks from the first low cycle of tx_o to the IDLE return.
- Back-to-back transfers:
  - tx_ready is high in the first IDLE cycle after tx_done.
  - If tx_valid is held high, the next start bit begins one cycle after that.
  - The minimum idle gap between frames is 1 clk beyond the stop bits.
- Not ready:
  - tx_valid while tx_ready = 0 is ignored; no queuing.
  - tx_data_in changes during a frame have no effect.
- Reset mid-frame: the frame is aborted, tx_o returns high on that edge, and no tx_done pulse is generated.
- tx_o is always driven from a flop; there are no combinational glitches on the line.

Test Plan:
- Bench settings: CLK_FREQ = 1_000_000, BAUD_RATE = 100_000, so BAUD_DIV = 10.
- Defaults, send 0xA5:
  - tx_o is low 10 clk, then bits 1,0,1,0,0,1,0,1 for 10 clk each, then high 10 clk.
  - tx_done pulses exactly 100 clk after the first low cycle.
  - tx_busy is high for those 100 clk.
- PARITY = 2, send 0xA5 (four ones): parity bit = 0 and the frame is 110 clk.
- PARITY = 1, send 0xA5: parity bit = 1.
- PARITY = 1, send 0x01: parity bit = 0.
- STOP_BITS = 2, MSB_FIRST = 0, send 0x3C:
  - Data bits on the line are 0,0,1,1,1,1,0,0.
  - tx_o stays high for 20 clk before tx_done.
- tx_valid held high with 0x55 then 0xAA:
  - The second start bit begins 1 clk after tx_done.
  - A tx_valid pulse applied mid-frame is ignored; exactly two frames are sent.
- Assert reset at clk 35 of a frame:
  - tx_o = 1 on the next edge; tx_busy = 0; tx_ready = 1; no tx_done.
  - A subsequent send of 0x0F completes correctly.
